ram_rd_stream: RTL and testbench

- Read-side sequencer for the single-port pseudo-RAM buffers (264-bit × 2048 default).
- On a start command, walks a contiguous address range and streams the words out on a valid/ready interface. Typical consumers are the PE array input and the writeback DMA.
- Drives the RAM address port while busy. Port arbitration with the write side is external. The RAM read is combinational, so one word can be fetched per cycle.

---
 rtl/ram_rd_stream_pkg.sv | 13 +
 rtl/ram_rd_obuf.sv | 33 +++
 rtl/ram_rd_stream.sv | 119 +++++++++++
 tb/tb_ram_rd_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_stream_pkg.sv
// Shared types and default geometry for the RAM read-side stream sequencer.
package ram_rd_stream_pkg;

  localparam int unsigned RD_WIDTH_DEF = 264;
  localparam int unsigned RD_DEPTH_DEF = 2048;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_DONE  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ram_rd_obuf.sv
// One-entry registered output stage: loads a RAM word, holds it under
// back-pressure and drops valid only after a handshake.
module ram_rd_obuf #(
  parameter int unsigned WIDTH = 264
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      // NOTE: the data register is reset too, so a wide beat never shows X after reset.
      o_data  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_last  <= i_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_rd_stream.sv
// Read sequencer: streams a contiguous (optionally strided, wrapping) range of
// RAM words onto a valid/ready port. Define RAM_RD_STRIDE_EN to add i_stride.
module ram_rd_stream
  import ram_rd_stream_pkg::*;
#(
  parameter int unsigned WIDTH  = RD_WIDTH_DEF,
  parameter int unsigned DEPTH  = RD_DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
`ifdef RAM_RD_STRIDE_EN
  input  logic [ADDR_W-1:0] i_stride,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [WIDTH-1:0]  i_ram_data,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_last,
  input  logic              i_ready
);

  localparam logic [ADDR_W+1:0] DEPTH_X1 = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_X2 = (ADDR_W+2)'(2 * DEPTH);

  rd_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W+1:0] addr_sum;
  logic              load;
  logic              last_hs;

`ifndef RAM_RD_STRIDE_EN
  assign stride_q = ADDR_W'(1);
`endif

  assign o_ram_addr = addr_q;
  assign load       = (state == RD_FETCH) && (!o_valid || i_ready) && (rem_q != '0);
  assign last_hs    = (state == RD_FETCH) && o_valid && i_ready && o_last;

  // Wrap modulo DEPTH; stride can reach 2*DEPTH-1 when DEPTH is not a power of two.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    addr_sum  = {2'b00, addr_q} + {2'b00, stride_q};
    addr_next = addr_sum[ADDR_W-1:0];
    if (addr_sum >= DEPTH_X2) begin
      addr_next = ADDR_W'(addr_sum - DEPTH_X2);
    end else if (addr_sum >= DEPTH_X1) begin
      addr_next = ADDR_W'(addr_sum - DEPTH_X1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= RD_IDLE;
      addr_q <= '0;
      rem_q  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
`ifdef RAM_RD_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      // NOTE: o_done is defaulted low each cycle with a non-blocking assignment, making it a pulse.
      o_done <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (i_start) begin
            addr_q <= i_base_addr;
            rem_q  <= i_len;
`ifdef RAM_RD_STRIDE_EN
            stride_q <= i_stride;
`endif
            if (i_len != '0) begin
              state  <= RD_FETCH;
              o_busy <= 1'b1;
            end else begin
              state  <= RD_DONE;
              o_done <= 1'b1;
            end
          end
        end
        RD_FETCH: begin
          if (load) begin
            addr_q <= addr_next;
            rem_q  <= rem_q - (ADDR_W+1)'(1);
          end
          if (last_hs) begin
            state  <= RD_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        RD_DONE: state <= RD_IDLE;
        default: state <= RD_IDLE;
      endcase
    end
  end

  ram_rd_obuf #(.WIDTH(WIDTH)) u_obuf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (load),
    .i_ready (i_ready),
    .i_data  (i_ram_data),
    .i_last  (rem_q == (ADDR_W+1)'(1)),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last)
  );

endmodule

// File: tb/tb_ram_rd_stream.sv
// Scoreboard bench for ram_rd_stream: expected beats come from modular address
// arithmetic over a bench-owned RAM image; a negedge monitor pops and compares.
module tb_ram_rd_stream;

  localparam int WIDTH  = 264;
  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 11;
`ifdef RAM_RD_STRIDE_EN
  localparam bit HAS_STRIDE = 1'b1;
`else
  localparam bit HAS_STRIDE = 1'b0;
`endif

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              ready = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] stride = '0;
  logic [ADDR_W:0]   len = '0;
  logic              busy, done, valid, last;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_data, data;
  logic [WIDTH-1:0]  mem [DEPTH];

  beat_t exp_q [$];
  int    checks = 0;
  int    failures = 0;
  int    hs_count = 0;
  int    done_count = 0;
  int    ready_mode = 0;
  int    rdy_cyc = 0;
  logic  prev_stall = 1'b0;
  logic  prev_done = 1'b0;
  beat_t prev_beat;

  always #5 clk = ~clk;

  assign ram_data = mem[ram_addr];

  ram_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_len       (len),
`ifdef RAM_RD_STRIDE_EN
    .i_stride    (stride),
`endif
    .o_busy      (busy),
    .o_done      (done),
    .o_ram_addr  (ram_addr),
    .i_ram_data  (ram_data),
    .o_valid     (valid),
    .o_data      (data),
    .o_last      (last),
    .i_ready     (ready)
  );

  task automatic check_w(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Consumer: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = (rdy_cyc % 3 == 0);
      default: ready = 1'($urandom_range(0, 1));
    endcase
    rdy_cyc++;
  end

  // Monitor: handshakes, stall stability and o_done pulse shape.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check_b("stall_valid", valid, 1'b1);
        check_w("stall_data", data, prev_beat.data);
        check_b("stall_last", last, prev_beat.last);
      end
      if (valid && ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check_b("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_w("beat_data", data, e.data);
          check_b("beat_last", last, e.last);
        end
      end
      if (done) begin
        done_count++;
        check_b("done_single", prev_done, 1'b0);
        check_b("done_not_busy", busy, 1'b0);
        check_b("done_no_valid", valid, 1'b0);
      end
      prev_stall     = valid && !ready;
      prev_beat.data = data;
      prev_beat.last = last;
      prev_done      = done;
    end
  end

  task automatic push_expected(input int b, input int l, input int s);
    beat_t e;
    for (int k = 0; k < l; k++) begin
      e.data = mem[(b + k * s) % DEPTH];
      e.last = (k == l - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_cmd(input int b, input int l, input int s, input int mode, input bit poke);
    int hs0, dn0, cyc;
    ready_mode = mode;
    push_expected(b, l, s);
    hs0 = hs_count;
    dn0 = done_count;
    @(posedge clk); #1;
    base_addr = ADDR_W'(b);
    len       = (ADDR_W+1)'(l);
    stride    = ADDR_W'(s);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    len       = (ADDR_W+1)'($urandom_range(1, DEPTH));
    stride    = ADDR_W'($urandom);
    @(negedge clk);
    check_w("first_addr", WIDTH'(ram_addr), WIDTH'(b));
    if (l != 0) check_b("busy_after_start", busy, 1'b1);
    cyc = 1;
    while (!done && cyc < 20000) begin
      start = poke && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      check_b("done_timeout", 1'b0, 1'b1);
      exp_q.delete();
      return;
    end
    if (mode == 0) check_i("done_latency", cyc, (l == 0) ? 1 : l + 2);
    // A start presented during DONE must be dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_b("idle_not_busy", busy, 1'b0);
    @(negedge clk); #1;
    check_b("start_in_done_ignored", busy, 1'b0);
    check_i("handshakes", hs_count - hs0, l);
    check_i("queue_drained", exp_q.size(), 0);
    check_i("done_pulses", done_count - dn0, 1);
    check_w("end_addr", WIDTH'(ram_addr), WIDTH'((b + l * s) % DEPTH));
  endtask

  task automatic reset_mid_command();
    int hs0, dn0, guard;
    ready_mode = 0;
    push_expected(40, 8, 1);
    hs0 = hs_count;
    @(posedge clk); #1;
    base_addr = ADDR_W'(40);
    len       = (ADDR_W+1)'(8);
    stride    = ADDR_W'(1);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (hs_count - hs0 < 2 && guard < 50) begin
      @(negedge clk); #2;
      guard++;
    end
    check_i("handshakes_before_reset", hs_count - hs0, 2);
    rst_n = 1'b0;
    #1;
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_done", done, 1'b0);
    check_b("rst_valid", valid, 1'b0);
    check_b("rst_last", last, 1'b0);
    check_w("rst_data", data, '0);
    check_w("rst_addr", WIDTH'(ram_addr), '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn0 = done_count;
    repeat (6) @(negedge clk);
    #1;
    check_i("no_done_after_reset", done_count - dn0, 0);
    check_b("idle_after_reset", busy, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l, s, m;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = WIDTH'(i) | (WIDTH'($urandom) << 32) | (WIDTH'($urandom) << 200);
    end
    #2 rst_n = 1'b0;
    #13;
    check_b("reset_busy", busy, 1'b0);
    check_b("reset_done", done, 1'b0);
    check_b("reset_valid", valid, 1'b0);
    check_b("reset_last", last, 1'b0);
    check_w("reset_data", data, '0);
    check_w("reset_addr", WIDTH'(ram_addr), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(10, 4, 1, 0, 1'b0);
    run_cmd(10, 4, 1, 1, 1'b0);
    run_cmd(DEPTH - 2, 4, 1, 0, 1'b0);
    run_cmd(5, 0, 1, 0, 1'b0);
    run_cmd(100, 6, 1, 2, 1'b1);
    reset_mid_command();
    run_cmd(0, 1, 1, 0, 1'b0);
    run_cmd(DEPTH - 1, 2, 1, 1, 1'b0);
    run_cmd(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1, 2, 1'b0);
    if (HAS_STRIDE) begin
      run_cmd(0, 4, 3, 0, 1'b0);
      run_cmd(0, 3, 0, 0, 1'b0);
      run_cmd(DEPTH - 5, 5, 700, 2, 1'b1);
    end

    for (int n = 0; n < 25; n++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(0, 40));
      s = HAS_STRIDE ? int'($urandom_range(0, DEPTH - 1)) : 1;
      m = int'($urandom_range(0, 2));
      run_cmd(b, l, s, m, (l >= 3) && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
